drawing_rect_fill: RTL and testbench
====================================

DRAWING_RECT_FILL -- requirements
Module: drawing_rect_fill

Interface
REQ-001 The block SHALL take parameter SCREEN_W, default 640, meaning bytes per raster line; it SHALL be a multiple of 4.
REQ-002 The block SHALL take parameter SCREEN_H, default 480, meaning raster lines.
REQ-003 The block SHALL take parameter ADDR_W, default 18, meaning word-address width.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 The ports SHALL be:
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- req  in  1  command request.
- ack  out  1  command accepted, 1-cycle pulse.
- busy  out  1  command in progress.
- r0..r3  in  16 each  X, Y, W, H in bytes/lines.
- r4  in  16  colour: [15:8] AND mask, [7:0] XOR mask.
- r5..r7  in  16 each  unused.
- de_req  out  1  bus request.
- de_ack  in  1  bus grant.
- de_addr  out  ADDR_W  word address.
- de_nbyte  out  4  active-low byte enables.
- de_rnw  out  1  1 = read.
- de_w_data  out  32  write data.
- de_r_data  in  32  read data.

Function
REQ-006 Byte lanes SHALL map as follows: byte offset k (0..3) in a word is de_nbyte[3-k] and data bits [31-8k:24-8k].
REQ-007 The FSM SHALL use states IDLE, ACK, RD_REQ, RD_WAIT, RD_DATA, WR_REQ and NEXT.
REQ-008 In IDLE, req=1 SHALL move the FSM to ACK; ack SHALL be 1 only in ACK; busy SHALL be 1 in every state except IDLE.
REQ-009 In ACK the block SHALL latch r0..r4 and compute the first word address (r1*SCREEN_W+r0)>>2, the line end word ((r1*SCREEN_W+r0+r2-1)>>2), and the masks.
- Start mask SHALL disable offsets below r0 mod 4.
- End mask SHALL disable offsets above (r0+r2-1) mod 4.
- When a line occupies one word, both masks SHALL apply (bitwise OR).
REQ-010 If W=0 or H=0 (after clipping), the FSM SHALL go from ACK to IDLE with no de_req.
REQ-011 If the AND mask is 0x00, each word SHALL skip the read and go straight to WR_REQ; otherwise it SHALL go to RD_REQ.
REQ-012 de_req SHALL be 1 in RD_REQ and WR_REQ; de_rnw SHALL be 1 except in WR_REQ. de_req SHALL stay high until de_ack, and the address, nbyte and data SHALL hold stable while de_req is high.
REQ-013 Read sequencing SHALL be: RD_REQ with de_ack goes to RD_WAIT, then RD_DATA; in RD_DATA, de_w_data SHALL be loaded with (de_r_data & {4{AND}}) ^ {4{XOR}}.
REQ-014 On a skipped read, de_w_data SHALL be loaded with {4{XOR}}.
REQ-015 WR_REQ with de_ack SHALL go to NEXT.
REQ-016 NEXT SHALL advance to the next word (nbyte = end mask if it is the line's last word, else 0000), or to the next line's start word (+SCREEN_W/4, start mask), or to IDLE after the last word of the last line.
REQ-017 Address arithmetic SHALL wrap modulo 2^ADDR_W; all internal coordinate sums SHALL be 17 bits wide.
REQ-018 req SHALL be ignored while busy.

Reset
REQ-019 rst_n low SHALL force, asynchronously, state IDLE, ack=0, busy=0, de_req=0, de_addr=0, de_nbyte=4'b1111, de_w_data=0 and all internal registers to 0, including during a pending bus transfer.
REQ-020 After rst_n rises, the block SHALL accept req on the next clock edge.

Configuration
REQ-021 With macro DRAWING_RECT_CLIP_EN defined, the rectangle SHALL be clipped to the screen.
- X>=SCREEN_W or Y>=SCREEN_H SHALL be treated as empty.
- W SHALL be truncated to SCREEN_W-X and H to SCREEN_H-Y.
REQ-022 Without DRAWING_RECT_CLIP_EN, no clipping SHALL occur and out-of-screen addresses SHALL be issued as computed (wrapped per REQ-017).

Verification (SCREEN_W=640, defaults)
REQ-023 X=5, Y=2, W=10, H=2, r4=0xFF00 SHALL produce 6 read+write pairs at words 321,322,323,481,482,483, each pair using the same nbyte: 1000,0000,0001 on each line; writes SHALL equal the read data.
REQ-024 X=4, Y=0, W=2, H=1, r4=0x00AB SHALL produce no read and one write at word 1 with nbyte 0011 and data 0xABABABAB.
REQ-025 W=0 SHALL produce an ack pulse, busy high for at most 2 cycles and no de_req.
REQ-026 With DRAWING_RECT_CLIP_EN, X=636, Y=479, W=10, H=5, r4=0x00FF SHALL produce exactly one write at word 76799 with nbyte 0000.
REQ-027 A read returning 0x12345678 with r4=0xF00F SHALL produce write data 0x1F3F5F7F.
REQ-028 rst_n asserted while de_req is high in WR_REQ SHALL drop de_req and busy immediately; a new req after release SHALL complete normally.

Source files
------------

// File: rtl/drawing_rect_fill_if.sv
// Command and memory-bus bundle for the rectangle fill engine.
//
// Signals:
//   req/ack/busy     - command handshake (ack is a one-cycle accept pulse)
//   r0..r7           - command registers: X, Y, W, H, colour, three spares
//   de_req/de_ack    - memory bus request / grant
//   de_addr          - word address (ADDR_W bits)
//   de_nbyte         - active-low byte enables, byte offset k -> de_nbyte[3-k]
//   de_rnw           - 1 = read, 0 = write
//   de_w_data        - write data
//   de_r_data        - read data
//
// Modports:
//   master - the side issuing commands and serving the memory bus
//   slave  - the fill engine itself
interface drawing_rect_fill_if #(
    parameter int ADDR_W = 18
);
    logic              req;
    logic              ack;
    logic              busy;
    logic [15:0]       r0;
    logic [15:0]       r1;
    logic [15:0]       r2;
    logic [15:0]       r3;
    logic [15:0]       r4;
    logic [15:0]       r5;
    logic [15:0]       r6;
    logic [15:0]       r7;
    logic              de_req;
    logic              de_ack;
    logic [ADDR_W-1:0] de_addr;
    logic [3:0]        de_nbyte;
    logic              de_rnw;
    logic [31:0]       de_w_data;
    logic [31:0]       de_r_data;

    modport master (
        output req, r0, r1, r2, r3, r4, r5, r6, r7, de_ack, de_r_data,
        input  ack, busy, de_req, de_addr, de_nbyte, de_rnw, de_w_data
    );

    modport slave (
        input  req, r0, r1, r2, r3, r4, r5, r6, r7, de_ack, de_r_data,
        output ack, busy, de_req, de_addr, de_nbyte, de_rnw, de_w_data
    );
endinterface

// File: rtl/drawing_rect_fill.sv
// Rectangle fill engine: walks an X/Y/W/H rectangle of a byte-per-pixel
// frame buffer word by word and applies pixel = (pixel & AND) ^ XOR,
// where r4[15:8] is the AND mask and r4[7:0] the XOR mask. When the AND
// mask is zero the old pixel value is irrelevant, so the read is skipped.
//
// Ports:
//   clk    - clock
//   rst_n  - asynchronous active-low reset
//   bus    - drawing_rect_fill_if.slave (command handshake + memory bus)
//
// Optional feature: define DRAWING_RECT_CLIP_EN to clip the rectangle to
// the SCREEN_W x SCREEN_H screen. Without it, coordinates are used as given
// and addresses simply wrap modulo 2^ADDR_W.
module drawing_rect_fill #(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int ADDR_W   = 18
) (
    input  logic clk,
    input  logic rst_n,
    drawing_rect_fill_if.slave bus
);
    // Byte addresses carry two extra bits below the word address.
    localparam int BA_W = ADDR_W + 2;
    localparam logic [16:0]       SW_C       = 17'(SCREEN_W);
    localparam logic [16:0]       SH_C       = 17'(SCREEN_H);
    localparam logic [BA_W-1:0]   SW_BA      = BA_W'(SCREEN_W);
    localparam logic [ADDR_W-1:0] LINE_WORDS = ADDR_W'(SCREEN_W / 4);
    localparam logic [ADDR_W-1:0] ONE_WORD   = ADDR_W'(1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ACK     = 3'd1,
        RD_REQ  = 3'd2,
        RD_WAIT = 3'd3,
        RD_DATA = 3'd4,
        WR_REQ  = 3'd5,
        NEXT    = 3'd6
    } state_t;

    // Disable byte offsets left of the first pixel in the start word.
    function automatic logic [3:0] start_mask(input logic [1:0] off);
        case (off)
            2'd0:    start_mask = 4'b0000;
            2'd1:    start_mask = 4'b1000;
            2'd2:    start_mask = 4'b1100;
            2'd3:    start_mask = 4'b1110;
            default: start_mask = 4'b0000;
        endcase
    endfunction

    // Disable byte offsets right of the last pixel in the end word.
    function automatic logic [3:0] end_mask(input logic [1:0] off);
        case (off)
            2'd0:    end_mask = 4'b0111;
            2'd1:    end_mask = 4'b0011;
            2'd2:    end_mask = 4'b0001;
            2'd3:    end_mask = 4'b0000;
            default: end_mask = 4'b0000;
        endcase
    endfunction

    state_t            state_r;
    logic              ack_r;
    logic              busy_r;
    logic              de_req_r;
    logic              de_rnw_r;
    logic [ADDR_W-1:0] de_addr_r;
    logic [3:0]        de_nbyte_r;
    logic [31:0]       de_w_data_r;
    logic [ADDR_W-1:0] line_start_r;
    logic [ADDR_W-1:0] line_end_r;
    logic [15:0]       lines_left_r;
    logic [3:0]        smask_r;
    logic [3:0]        emask_r;
    logic              single_r;
    logic [7:0]        and_r;
    logic [7:0]        xor_r;

    logic [16:0]       x_s;
    logic [16:0]       y_s;
    logic [16:0]       w_s;
    logic [16:0]       h_s;
    logic [16:0]       w_eff_s;
    logic [16:0]       h_eff_s;
    logic [16:0]       last_x_s;
    logic [BA_W-1:0]   start_byte_s;
    logic [BA_W-1:0]   end_byte_s;
    logic              empty_s;
    logic              single_s;
    logic [3:0]        smask_s;
    logic [3:0]        emask_s;
    logic [ADDR_W-1:0] adv_addr_s;
    logic [ADDR_W-1:0] nxt_start_s;
    logic [ADDR_W-1:0] nxt_end_s;
    logic              unused_s;

    assign bus.ack       = ack_r;
    assign bus.busy      = busy_r;
    assign bus.de_req    = de_req_r;
    assign bus.de_rnw    = de_rnw_r;
    assign bus.de_addr   = de_addr_r;
    assign bus.de_nbyte  = de_nbyte_r;
    assign bus.de_w_data = de_w_data_r;

    // Spare command registers and the sub-word byte-address bits (already
    // covered by the x offsets since lines are word aligned) carry no logic.
    assign unused_s = ^{bus.r5, bus.r6, bus.r7, start_byte_s[1:0],
                        end_byte_s[1:0], h_eff_s[16], SH_C};

    // Command geometry (used in ACK) and next-word/next-line addresses.
    always_comb begin
        x_s = {1'b0, bus.r0};
        y_s = {1'b0, bus.r1};
        w_s = {1'b0, bus.r2};
        h_s = {1'b0, bus.r3};
`ifdef DRAWING_RECT_CLIP_EN
        if (x_s >= SW_C || y_s >= SH_C) begin
            w_eff_s = 17'd0;
            h_eff_s = 17'd0;
        end else begin
            w_eff_s = (w_s > (SW_C - x_s)) ? (SW_C - x_s) : w_s;
            h_eff_s = (h_s > (SH_C - y_s)) ? (SH_C - y_s) : h_s;
        end
`else
        w_eff_s = w_s;
        h_eff_s = h_s;
`endif
        last_x_s     = x_s + w_eff_s - 17'd1;
        start_byte_s = BA_W'(y_s) * SW_BA + BA_W'(x_s);
        end_byte_s   = BA_W'(y_s) * SW_BA + BA_W'(last_x_s);
        empty_s      = (w_eff_s == 17'd0) || (h_eff_s == 17'd0);
        single_s     = (start_byte_s[BA_W-1:2] == end_byte_s[BA_W-1:2]);
        smask_s      = start_mask(x_s[1:0]);
        emask_s      = end_mask(last_x_s[1:0]);
        adv_addr_s   = de_addr_r + ONE_WORD;
        nxt_start_s  = line_start_r + LINE_WORDS;
        nxt_end_s    = line_end_r + LINE_WORDS;
    end

    // Control FSM; every output is registered and updated alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            ack_r        <= 1'b0;
            busy_r       <= 1'b0;
            de_req_r     <= 1'b0;
            de_rnw_r     <= 1'b1;
            de_addr_r    <= '0;
            de_nbyte_r   <= 4'b1111;
            de_w_data_r  <= 32'd0;
            line_start_r <= '0;
            line_end_r   <= '0;
            lines_left_r <= 16'd0;
            smask_r      <= 4'd0;
            emask_r      <= 4'd0;
            single_r     <= 1'b0;
            and_r        <= 8'd0;
            xor_r        <= 8'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.req) begin
                        state_r <= ACK;
                        ack_r   <= 1'b1;
                        busy_r  <= 1'b1;
                    end else begin
                        ack_r   <= 1'b0;
                        busy_r  <= 1'b0;
                    end
                end
                ACK: begin
                    ack_r        <= 1'b0;
                    and_r        <= bus.r4[15:8];
                    xor_r        <= bus.r4[7:0];
                    smask_r      <= smask_s;
                    emask_r      <= emask_s;
                    single_r     <= single_s;
                    line_start_r <= start_byte_s[BA_W-1:2];
                    line_end_r   <= end_byte_s[BA_W-1:2];
                    lines_left_r <= h_eff_s[15:0];
                    if (empty_s) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        de_addr_r  <= start_byte_s[BA_W-1:2];
                        // A one-word line needs both edges masked at once.
                        de_nbyte_r <= single_s ? (smask_s | emask_s) : smask_s;
                        de_req_r   <= 1'b1;
                        if (bus.r4[15:8] == 8'd0) begin
                            de_w_data_r <= {4{bus.r4[7:0]}};
                            de_rnw_r    <= 1'b0;
                            state_r     <= WR_REQ;
                        end else begin
                            de_rnw_r    <= 1'b1;
                            state_r     <= RD_REQ;
                        end
                    end
                end
                RD_REQ: begin
                    if (bus.de_ack) begin
                        de_req_r <= 1'b0;
                        state_r  <= RD_WAIT;
                    end else begin
                        state_r  <= RD_REQ;
                    end
                end
                RD_WAIT: begin
                    state_r <= RD_DATA;
                end
                RD_DATA: begin
                    de_w_data_r <= (bus.de_r_data & {4{and_r}}) ^ {4{xor_r}};
                    de_req_r    <= 1'b1;
                    de_rnw_r    <= 1'b0;
                    state_r     <= WR_REQ;
                end
                WR_REQ: begin
                    if (bus.de_ack) begin
                        de_req_r <= 1'b0;
                        de_rnw_r <= 1'b1;
                        state_r  <= NEXT;
                    end else begin
                        state_r  <= WR_REQ;
                    end
                end
                NEXT: begin
                    if ((de_addr_r == line_end_r) && (lines_left_r == 16'd1)) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        if (de_addr_r == line_end_r) begin
                            line_start_r <= nxt_start_s;
                            line_end_r   <= nxt_end_s;
                            lines_left_r <= lines_left_r - 16'd1;
                            de_addr_r    <= nxt_start_s;
                            de_nbyte_r   <= single_r ? (smask_r | emask_r) : smask_r;
                        end else begin
                            de_addr_r    <= adv_addr_s;
                            de_nbyte_r   <= (adv_addr_s == line_end_r) ? emask_r : 4'b0000;
                        end
                        de_req_r <= 1'b1;
                        if (and_r == 8'd0) begin
                            de_w_data_r <= {4{xor_r}};
                            de_rnw_r    <= 1'b0;
                            state_r     <= WR_REQ;
                        end else begin
                            de_rnw_r    <= 1'b1;
                            state_r     <= RD_REQ;
                        end
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    ack_r    <= 1'b0;
                    busy_r   <= 1'b0;
                    de_req_r <= 1'b0;
                    de_rnw_r <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_drawing_rect_fill.sv
// Self-checking bench for drawing_rect_fill (SCREEN_W=640, SCREEN_H=480,
// ADDR_W=18). A byte-coverage model pushes the expected bus transfers of
// each command into a scoreboard queue; the bus responder pops and compares
// every granted transfer. Clip tests exist only with DRAWING_RECT_CLIP_EN.
module tb_drawing_rect_fill;
    typedef struct packed {
        logic        rnw;
        logic [17:0] addr;
        logic [3:0]  nbyte;
        logic [31:0] data;
    } xfer_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    drawing_rect_fill_if #(.ADDR_W(18)) bus();

    drawing_rect_fill #(.SCREEN_W(640), .SCREEN_H(480), .ADDR_W(18)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    xfer_t       sb[$];
    xfer_t       mon_exp;
    int          pass_cnt = 0;
    int          total_cnt = 0;
    bit          no_grant = 1'b0;
    bit          rd_fixed = 1'b0;
    logic [31:0] rd_seed = 32'd0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    logic [31:0] last_wr_data = 32'd0;
    logic [17:0] last_wr_addr = 18'd0;
    bit          prev_req = 1'b0;
    logic [54:0] prev_bundle = 55'd0;

    function automatic logic [31:0] mem_val(input logic [17:0] a);
        if (rd_fixed) return rd_seed;
        return {a, a[13:0]} ^ 32'h5AC3_96E1;
    endfunction

    // Expected transfers derived from which bytes of each word the rectangle covers.
    task automatic push_expected(input int x, input int y, input int w, input int h,
                                 input logic [15:0] c);
        longint base, s, e, fw, lw, ba;
        logic [3:0] nb;
        xfer_t it;
`ifdef DRAWING_RECT_CLIP_EN
        if (x >= 640 || y >= 480) return;
        if (w > 640 - x) w = 640 - x;
        if (h > 480 - y) h = 480 - y;
`endif
        if (w == 0 || h == 0) return;
        for (int l = 0; l < h; l++) begin
            base = longint'(y + l) * 640;
            s = base + x;
            e = s + w - 1;
            fw = s / 4;
            lw = e / 4;
            for (longint wd = fw; wd <= lw; wd++) begin
                for (int k = 0; k < 4; k++) begin
                    ba = wd * 4 + k;
                    nb[3-k] = !((ba >= s) && (ba <= e));
                end
                it.addr  = 18'(wd);
                it.nbyte = nb;
                if (c[15:8] != 8'h00) begin
                    it.rnw  = 1'b1;
                    it.data = 32'd0;
                    sb.push_back(it);
                    it.data = (mem_val(18'(wd)) & {4{c[15:8]}}) ^ {4{c[7:0]}};
                end else begin
                    it.data = {4{c[7:0]}};
                end
                it.rnw = 1'b0;
                sb.push_back(it);
            end
        end
    endtask

    // Bus responder and scoreboard: random grants, stability and transfer checks.
    always @(negedge clk) begin
        if (!rst_n) begin
            bus.de_ack    = 1'b0;
            bus.de_r_data = 32'd0;
            prev_req      = 1'b0;
        end else begin
            if (bus.de_req && prev_req) begin
                total_cnt++;
                if ({bus.de_rnw, bus.de_addr, bus.de_nbyte, bus.de_w_data} !== prev_bundle)
                    $display("FAIL bus_stable got %h want %h",
                             {bus.de_rnw, bus.de_addr, bus.de_nbyte, bus.de_w_data}, prev_bundle);
                else
                    pass_cnt++;
            end
            prev_req    = bus.de_req;
            prev_bundle = {bus.de_rnw, bus.de_addr, bus.de_nbyte, bus.de_w_data};
            if (bus.de_req && !bus.de_ack && !no_grant && ($urandom_range(0, 2) != 0)) begin
                bus.de_ack = 1'b1;
                total_cnt++;
                if (sb.size() == 0) begin
                    $display("FAIL sb_unexpected got rnw=%b addr=%0d nbyte=%b data=%h want no transfer",
                             bus.de_rnw, bus.de_addr, bus.de_nbyte, bus.de_w_data);
                end else begin
                    mon_exp = sb.pop_front();
                    if (bus.de_rnw !== mon_exp.rnw || bus.de_addr !== mon_exp.addr ||
                        bus.de_nbyte !== mon_exp.nbyte ||
                        (!mon_exp.rnw && bus.de_w_data !== mon_exp.data))
                        $display("FAIL sb_xfer got rnw=%b addr=%0d nbyte=%b data=%h want rnw=%b addr=%0d nbyte=%b data=%h",
                                 bus.de_rnw, bus.de_addr, bus.de_nbyte, bus.de_w_data,
                                 mon_exp.rnw, mon_exp.addr, mon_exp.nbyte, mon_exp.data);
                    else
                        pass_cnt++;
                end
                if (bus.de_rnw) begin
                    rd_cnt++;
                    bus.de_r_data = mem_val(bus.de_addr);
                end else begin
                    wr_cnt++;
                    last_wr_data = bus.de_w_data;
                    last_wr_addr = bus.de_addr;
                end
            end else begin
                bus.de_ack = 1'b0;
            end
        end
    end

    task automatic issue_cmd(input int x, input int y, input int w, input int h,
                             input logic [15:0] c, input bit poke,
                             output int ack_n, output int busy_n, output int req_n,
                             output bit to);
        bit done;
        ack_n = 0; busy_n = 0; req_n = 0; done = 1'b0;
        push_expected(x, y, w, h, c);
        @(negedge clk);
        bus.r0 = 16'(x); bus.r1 = 16'(y); bus.r2 = 16'(w); bus.r3 = 16'(h);
        bus.r4 = c;
        bus.req = 1'b1;
        for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
            @(negedge clk);
            if (cyc == 0) bus.req = 1'b0;
            if (poke && cyc == 3) bus.req = 1'b1;
            if (poke && cyc == 4) bus.req = 1'b0;
            if (bus.ack) ack_n++;
            if (bus.busy) busy_n++;
            if (bus.de_req) req_n++;
            if (!bus.busy && cyc >= 1) done = 1'b1;
        end
        to = !done;
        bus.req = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({bus.ack, bus.busy, bus.de_req} !== 3'b000)
            $display("FAIL reset_ctrl got %b want 000", {bus.ack, bus.busy, bus.de_req});
        else pass_cnt++;
        total_cnt++;
        if (bus.de_addr !== 18'd0) $display("FAIL reset_addr got %h want 0", bus.de_addr);
        else pass_cnt++;
        total_cnt++;
        if (bus.de_nbyte !== 4'b1111) $display("FAIL reset_nbyte got %b want 1111", bus.de_nbyte);
        else pass_cnt++;
        total_cnt++;
        if (bus.de_w_data !== 32'd0) $display("FAIL reset_wdata got %h want 0", bus.de_w_data);
        else pass_cnt++;
        rst_n = 1'b1;
    endtask

    task automatic test_basic_rmw();
        int a, b, q, rd0, wr0; bit to;
        rd0 = rd_cnt; wr0 = wr_cnt;
        issue_cmd(5, 2, 10, 2, 16'hFF00, 1'b0, a, b, q, to);
        total_cnt++;
        if (to || a != 1) $display("FAIL rmw_done got to=%0d ack=%0d want to=0 ack=1", to, a);
        else pass_cnt++;
        total_cnt++;
        if (rd_cnt - rd0 != 6 || wr_cnt - wr0 != 6 || sb.size() != 0)
            $display("FAIL rmw_counts got rd=%0d wr=%0d left=%0d want 6 6 0",
                     rd_cnt - rd0, wr_cnt - wr0, sb.size());
        else pass_cnt++;
    endtask

    task automatic test_skip_read();
        int a, b, q, rd0, wr0; bit to;
        rd0 = rd_cnt; wr0 = wr_cnt;
        issue_cmd(4, 0, 2, 1, 16'h00AB, 1'b0, a, b, q, to);
        total_cnt++;
        if (to || rd_cnt != rd0 || wr_cnt - wr0 != 1 || sb.size() != 0)
            $display("FAIL skip_counts got to=%0d rd=%0d wr=%0d want 0 0 1", to, rd_cnt - rd0, wr_cnt - wr0);
        else pass_cnt++;
        total_cnt++;
        if (last_wr_data !== 32'hABABABAB || last_wr_addr !== 18'd1)
            $display("FAIL skip_write got %h@%0d want abababab@1", last_wr_data, last_wr_addr);
        else pass_cnt++;
    endtask

    task automatic test_zero_size();
        int a, b, q; bit to;
        issue_cmd(7, 3, 0, 4, 16'h1234, 1'b0, a, b, q, to);
        total_cnt++;
        if (to || a != 1 || b < 1 || b > 2 || q != 0)
            $display("FAIL zero_w got to=%0d ack=%0d busy=%0d de_req=%0d want 0 1 1..2 0", to, a, b, q);
        else pass_cnt++;
        issue_cmd(7, 3, 4, 0, 16'h1234, 1'b0, a, b, q, to);
        total_cnt++;
        if (to || a != 1 || q != 0)
            $display("FAIL zero_h got to=%0d ack=%0d de_req=%0d want 0 1 0", to, a, q);
        else pass_cnt++;
    endtask

    task automatic test_color_math();
        int a, b, q; bit to;
        rd_fixed = 1'b1;
        rd_seed = 32'h12345678;
        issue_cmd(8, 1, 4, 1, 16'hF00F, 1'b0, a, b, q, to);
        total_cnt++;
        if (to || last_wr_data !== 32'h1F3F5F7F || sb.size() != 0)
            $display("FAIL color_math got %h want 1f3f5f7f", last_wr_data);
        else pass_cnt++;
        rd_fixed = 1'b0;
    endtask

    task automatic test_req_ignored_busy();
        int a, b, q; bit to;
        issue_cmd(0, 5, 40, 2, 16'h0F0F, 1'b1, a, b, q, to);
        total_cnt++;
        if (to || a != 1 || sb.size() != 0)
            $display("FAIL req_while_busy got to=%0d ack=%0d left=%0d want 0 1 0", to, a, sb.size());
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int a, b, q; bit to; logic [15:0] c;
        for (int i = 0; i < 6; i++) begin
            c = 16'($urandom);
            if (i % 3 == 0) c[15:8] = 8'h00;
            issue_cmd($urandom_range(0, 60), $urandom_range(0, 20), $urandom_range(0, 13),
                      $urandom_range(0, 3), c, 1'b0, a, b, q, to);
            total_cnt++;
            if (to || a != 1 || sb.size() != 0)
                $display("FAIL back_to_back_%0d got to=%0d ack=%0d left=%0d want 0 1 0", i, to, a, sb.size());
            else pass_cnt++;
        end
    endtask

`ifdef DRAWING_RECT_CLIP_EN
    task automatic test_clip();
        int a, b, q, rd0, wr0; bit to;
        rd0 = rd_cnt; wr0 = wr_cnt;
        issue_cmd(636, 479, 10, 5, 16'h00FF, 1'b0, a, b, q, to);
        total_cnt++;
        if (to || rd_cnt != rd0 || wr_cnt - wr0 != 1 || last_wr_addr !== 18'd76799 || sb.size() != 0)
            $display("FAIL clip_corner got wr=%0d addr=%0d want 1 76799", wr_cnt - wr0, last_wr_addr);
        else pass_cnt++;
        issue_cmd(700, 10, 4, 4, 16'h00FF, 1'b0, a, b, q, to);
        total_cnt++;
        if (to || q != 0) $display("FAIL clip_offscreen got de_req=%0d want 0", q);
        else pass_cnt++;
    endtask
`endif

    task automatic test_reset_mid_transfer();
        int a, b, q, wr0; bit to, found;
        found = 1'b0;
        no_grant = 1'b1;
        @(negedge clk);
        bus.r0 = 16'd0; bus.r1 = 16'd0; bus.r2 = 16'd8; bus.r3 = 16'd1;
        bus.r4 = 16'h0055;
        bus.req = 1'b1;
        for (int cyc = 0; cyc < 20 && !found; cyc++) begin
            @(negedge clk);
            bus.req = 1'b0;
            if (bus.de_req && !bus.de_rnw) found = 1'b1;
        end
        total_cnt++;
        if (!found) $display("FAIL reach_wr_req got 0 want 1");
        else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({bus.de_req, bus.busy, bus.ack} !== 3'b000)
            $display("FAIL async_reset got %b want 000", {bus.de_req, bus.busy, bus.ack});
        else pass_cnt++;
        total_cnt++;
        if (bus.de_nbyte !== 4'b1111 || bus.de_addr !== 18'd0)
            $display("FAIL async_reset_bus got nbyte=%b addr=%0d want 1111 0", bus.de_nbyte, bus.de_addr);
        else pass_cnt++;
        sb.delete();
        no_grant = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wr0 = wr_cnt;
        issue_cmd(12, 4, 8, 1, 16'h3C5A, 1'b0, a, b, q, to);
        total_cnt++;
        if (to || a != 1 || wr_cnt - wr0 != 2 || sb.size() != 0)
            $display("FAIL after_reset got to=%0d ack=%0d wr=%0d want 0 1 2", to, a, wr_cnt - wr0);
        else pass_cnt++;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.req = 1'b0;
        bus.r0 = 16'd0; bus.r1 = 16'd0; bus.r2 = 16'd0; bus.r3 = 16'd0;
        bus.r4 = 16'd0; bus.r5 = 16'd0; bus.r6 = 16'd0; bus.r7 = 16'd0;
        test_reset();
        test_basic_rmw();
        test_skip_read();
        test_zero_size();
        test_color_math();
        test_req_ignored_busy();
        test_back_to_back();
`ifdef DRAWING_RECT_CLIP_EN
        test_clip();
`endif
        test_reset_mid_transfer();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
